// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 8-bit write controller.
// Command bytes, main/bus FSM encodings and a command lookup helper.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] LINE2     = 8'hC0;
    localparam logic [7:0] HOME_ADDR = 8'h80;

    localparam logic [3:0] S_PWR_WAIT = 4'd0;
    localparam logic [3:0] S_FS1      = 4'd1;
    localparam logic [3:0] S_FS2      = 4'd2;
    localparam logic [3:0] S_FS3      = 4'd3;
    localparam logic [3:0] S_DISP     = 4'd4;
    localparam logic [3:0] S_CLR      = 4'd5;
    localparam logic [3:0] S_ENTRY    = 4'd6;
    localparam logic [3:0] S_READY    = 4'd7;
    localparam logic [3:0] S_WR_LINE2 = 4'd8;
    localparam logic [3:0] S_WR_DATA  = 4'd9;
    localparam logic [3:0] S_WR_HOME  = 4'd10;
    localparam logic [3:0] S_ACK      = 4'd11;
    localparam logic [3:0] S_GAP      = 4'd12;

    localparam logic [2:0] B_PWR_LOAD = 3'd0;
    localparam logic [2:0] B_PWRUP    = 3'd1;
    localparam logic [2:0] B_IDLE     = 3'd2;
    localparam logic [2:0] B_SETUP    = 3'd3;
    localparam logic [2:0] B_ENABLE   = 3'd4;
    localparam logic [2:0] B_HOLD     = 3'd5;

    function automatic logic is_write(input logic [3:0] s);
        is_write = (s >= S_FS1 && s <= S_ENTRY) ||
                   (s >= S_WR_LINE2 && s <= S_WR_HOME);
    endfunction

    function automatic logic [7:0] cmd_of(input logic [3:0] s);
        case (s)
            S_FS1, S_FS2, S_FS3: cmd_of = FUNC_SET;
            S_DISP:              cmd_of = DISP_ON;
            S_CLR:               cmd_of = CLEAR;
            S_ENTRY:             cmd_of = ENTRY;
            S_WR_LINE2:          cmd_of = LINE2;
            S_WR_HOME:           cmd_of = HOME_ADDR;
            default:             cmd_of = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 bus write: SETUP -> ENABLE -> HOLD, plus the power-up wait.
// Owns the shared down-counter; done pulses on the last cycle of a wait.
module lcd_bus_cycle #(
    parameter int CNT_W       = 20,
    parameter int T_PWRUP_CYC = 750000,
    parameter int T_SETUP_CYC = 2,
    parameter int T_E_CYC     = 12,
    parameter int T_CMD_CYC   = 2500,
    parameter int T_CLR_CYC   = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       LCD_RS,
    output logic       LCD_E,
    output logic [7:0] LCD_DB,
    output logic       done,
    output logic       idle
);
    import lcd_pkg::*;

    logic [2:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             rs_q;
    logic [7:0]       db_q;
    logic             long_q;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign done     = cnt_zero && (st == B_PWRUP || st == B_HOLD);
    assign idle     = (st == B_IDLE);
    assign LCD_E    = (st == B_ENABLE);
    assign LCD_RS   = rs_q;
    assign LCD_DB   = db_q;

    // Phase sequencing; RS/DB latched at start and held through HOLD.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            st     <= B_PWR_LOAD;
            cnt    <= '0;
            rs_q   <= 1'b0;
            db_q   <= 8'h00;
            long_q <= 1'b0;
        end else begin
            case (st)
                B_PWR_LOAD: begin
                    cnt <= CNT_W'(T_PWRUP_CYC - 2);
                    st  <= B_PWRUP;
                end
                B_PWRUP: begin
                    if (cnt_zero) st <= B_IDLE;
                    else          cnt <= cnt - 1'b1;
                end
                B_IDLE: begin
                    if (start) begin
                        rs_q   <= rs;
                        db_q   <= data;
                        long_q <= long_wait;
                        cnt    <= CNT_W'(T_SETUP_CYC - 1);
                        st     <= B_SETUP;
                    end
                end
                B_SETUP: begin
                    if (cnt_zero) begin
                        cnt <= CNT_W'(T_E_CYC - 1);
                        st  <= B_ENABLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                B_ENABLE: begin
                    if (cnt_zero) begin
                        cnt <= long_q ? CNT_W'(T_CLR_CYC - 1)
                                      : CNT_W'(T_CMD_CYC - 1);
                        st  <= B_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                B_HOLD: begin
                    if (cnt_zero) begin
                        rs_q <= 1'b0;
                        db_q <= 8'h00;
                        st   <= B_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: st <= B_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_write_ctrl.sv
// HD44780 write controller: power-up init, then char/line-2 writes.
// Optional LCD_FRAME_HOME_EN: WrittenLCD rising issues a home (0x80) command.
module lcd_write_ctrl #(
    parameter int CNT_W       = 20,
    parameter int T_PWRUP_CYC = 750000,
    parameter int T_SETUP_CYC = 2,
    parameter int T_E_CYC     = 12,
    parameter int T_CMD_CYC   = 2500,
    parameter int T_CLR_CYC   = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] DatoLCD,
    input  logic       Lista,
    input  logic       Linea2,
    input  logic       WrittenLCD,
    output logic       Cuenta,
    output logic       InitDone,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DB
);
    import lcd_pkg::*;

    logic [3:0] state;
    logic [7:0] data_q;
    logic       init_q;
    logic       bus_start;
    logic       bus_rs;
    logic [7:0] bus_data;
    logic       bus_long;
    logic       bus_done;
    logic       bus_idle;
    logic       home_req;

    assign bus_start = is_write(state) && bus_idle;
    assign bus_rs    = (state == S_WR_DATA);
    assign bus_data  = bus_rs ? data_q : cmd_of(state);
    assign bus_long  = (state == S_CLR);
    assign Cuenta    = (state == S_ACK);
    assign InitDone  = init_q;
    assign LCD_RW    = 1'b0;

`ifdef LCD_FRAME_HOME_EN
    logic home_armed;

    assign home_req = home_armed && WrittenLCD;

    // One home command per WrittenLCD high period.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            home_armed <= 1'b1;
        else if (!WrittenLCD)
            home_armed <= 1'b1;
        else if (state == S_READY)
            home_armed <= 1'b0;
    end
`else
    logic unused_written;

    assign home_req       = 1'b0;
    assign unused_written = WrittenLCD;
`endif

    // Main sequencer: init chain, request arbitration, ack and gap.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= S_PWR_WAIT;
            data_q <= 8'h00;
            init_q <= 1'b0;
        end else begin
            case (state)
                S_PWR_WAIT: if (bus_done) state <= S_FS1;
                S_FS1:      if (bus_done) state <= S_FS2;
                S_FS2:      if (bus_done) state <= S_FS3;
                S_FS3:      if (bus_done) state <= S_DISP;
                S_DISP:     if (bus_done) state <= S_CLR;
                S_CLR:      if (bus_done) state <= S_ENTRY;
                S_ENTRY: begin
                    if (bus_done) begin
                        state  <= S_READY;
                        init_q <= 1'b1;
                    end
                end
                S_READY: begin
                    if (home_req) begin
                        state <= S_WR_HOME;
                    end else if (Linea2) begin
                        state <= S_WR_LINE2;
                    end else if (Lista) begin
                        state  <= S_WR_DATA;
                        data_q <= DatoLCD;
                    end
                end
                S_WR_LINE2: if (bus_done) state <= S_ACK;
                S_WR_DATA:  if (bus_done) state <= S_ACK;
                S_WR_HOME:  if (bus_done) state <= S_GAP;
                S_ACK:      state <= S_GAP;
                S_GAP:      state <= S_READY;
                default:    state <= S_PWR_WAIT;
            endcase
        end
    end

    lcd_bus_cycle #(
        .CNT_W      (CNT_W),
        .T_PWRUP_CYC(T_PWRUP_CYC),
        .T_SETUP_CYC(T_SETUP_CYC),
        .T_E_CYC    (T_E_CYC),
        .T_CMD_CYC  (T_CMD_CYC),
        .T_CLR_CYC  (T_CLR_CYC)
    ) u_bus (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (bus_start),
        .rs       (bus_rs),
        .data     (bus_data),
        .long_wait(bus_long),
        .LCD_RS   (LCD_RS),
        .LCD_E    (LCD_E),
        .LCD_DB   (LCD_DB),
        .done     (bus_done),
        .idle     (bus_idle)
    );

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Scoreboard bench for lcd_write_ctrl with shortened delays.
// Expected {RS,DB} writes are queued by stimulus and popped on each E rise.
module tb_lcd_write_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] DatoLCD = 8'h00;
    logic       Lista = 1'b0;
    logic       Linea2 = 1'b0;
    logic       WrittenLCD = 1'b0;
    logic       Cuenta;
    logic       InitDone;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [7:0] LCD_DB;

    lcd_write_ctrl #(
        .CNT_W      (20),
        .T_PWRUP_CYC(40),
        .T_SETUP_CYC(2),
        .T_E_CYC    (4),
        .T_CMD_CYC  (10),
        .T_CLR_CYC  (30)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .DatoLCD   (DatoLCD),
        .Lista     (Lista),
        .Linea2    (Linea2),
        .WrittenLCD(WrittenLCD),
        .Cuenta    (Cuenta),
        .InitDone  (InitDone),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_E     (LCD_E),
        .LCD_DB    (LCD_DB)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int cuenta_cnt = 0;
    int exp_cuenta = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic       e_prev = 1'b0;
    logic       cu_prev = 1'b0;
    logic       first_seen = 1'b0;
    logic       have_last = 1'b0;
    int         e_w = 0;
    int         cu_w = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    logic [8:0] cap = 9'h0;
    logic [8:0] last = 9'h0;

    // Bus and Cuenta monitor, sampled on the falling edge.
    always @(negedge Clk) begin
        if (!Reset) begin
            e_prev = 1'b0;
            cu_prev = 1'b0;
            first_seen = 1'b0;
            have_last = 1'b0;
            e_w = 0;
            cu_w = 0;
            cyc = 0;
        end else begin
            cyc++;
            if (LCD_E && !e_prev) begin
                if (!first_seen) begin
                    check("pwrup_wait", 32'(cyc >= 42), 1);
                    first_seen = 1'b1;
                end
                if (have_last && last == 9'h001)
                    check("clr_gap", 32'((cyc - fall_cyc) >= 30), 1);
                cap = {LCD_RS, LCD_DB};
                if (LCD_RS) check("data_before_init", 32'(InitDone), 1);
                check("wr_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0)
                    check("wr_value", 32'(cap), 32'(exp_q.pop_front()));
                e_w = 0;
            end
            if (LCD_E) e_w++;
            if (!LCD_E && e_prev) begin
                check("e_width", e_w, 4);
                check("bus_stable", 32'({LCD_RS, LCD_DB}), 32'(cap));
                fall_cyc = cyc;
                last = cap;
                have_last = 1'b1;
            end
            if (Cuenta) begin
                cuenta_cnt++;
                cu_w++;
                if (!cu_prev) check("cuenta_init", 32'(InitDone), 1);
            end
            if (!Cuenta && cu_prev) begin
                check("cuenta_width", cu_w, 1);
                cu_w = 0;
            end
            e_prev = LCD_E;
            cu_prev = Cuenta;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_cuenta(input int budget);
        int n = 0;
        @(negedge Clk);
        while (!Cuenta && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check("cuenta_seen", 32'(Cuenta), 1);
    endtask

    task automatic wait_init(input int budget);
        int n = 0;
        @(negedge Clk);
        while (!InitDone && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check("init_done", 32'(InitDone), 1);
    endtask

    task automatic wait_erise(input int budget);
        int n = 0;
        @(negedge Clk);
        while (!LCD_E && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check("e_seen", 32'(LCD_E), 1);
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    task automatic settle_and_check(input string tag);
        idle_cycles(40);
        check({tag, "_cuenta"}, cuenta_cnt, exp_cuenta);
        check({tag, "_queue"}, exp_q.size(), 0);
    endtask

    logic [7:0] pats[3] = '{8'h00, 8'hFF, 8'hA5};

    initial begin
        Lista = 1'b1;
        DatoLCD = 8'h50;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_e", 32'(LCD_E), 0);
        check("rst_rs", 32'(LCD_RS), 0);
        check("rst_rw", 32'(LCD_RW), 0);
        check("rst_db", 32'(LCD_DB), 0);
        check("rst_cuenta", 32'(Cuenta), 0);
        check("rst_init", 32'(InitDone), 0);

        push_init();
        exp_q.push_back({1'b1, 8'h50});
        exp_cuenta++;
        Reset = 1'b1;
        wait_init(1000);
        wait_cuenta(200);
        idle_cycles(1);
        Lista = 1'b0;
        settle_and_check("held_lista");

        DatoLCD = 8'h5A;
        Linea2 = 1'b1;
        Lista = 1'b1;
        exp_q.push_back({1'b0, 8'hC0});
        exp_q.push_back({1'b1, 8'h5A});
        exp_cuenta += 2;
        wait_cuenta(200);
        Linea2 = 1'b0;
        wait_cuenta(200);
        Lista = 1'b0;
        settle_and_check("line2_prio");

        for (int i = 0; i < 3; i++) begin
            DatoLCD = pats[i];
            Lista = 1'b1;
            exp_q.push_back({1'b1, pats[i]});
            exp_cuenta++;
            wait_cuenta(200);
            Lista = 1'b0;
            idle_cycles(3);
        end
        settle_and_check("patterns");

        WrittenLCD = 1'b1;
`ifdef LCD_FRAME_HOME_EN
        exp_q.push_back(9'h080);
`endif
        idle_cycles(100);
        WrittenLCD = 1'b0;
        idle_cycles(5);
        WrittenLCD = 1'b1;
`ifdef LCD_FRAME_HOME_EN
        exp_q.push_back(9'h080);
`endif
        idle_cycles(60);
        WrittenLCD = 1'b0;
        settle_and_check("home");

        DatoLCD = 8'h33;
        Lista = 1'b1;
        exp_q.push_back({1'b1, 8'h33});
        wait_erise(200);
        #1;
        Reset = 1'b0;
        #1;
        check("abort_e", 32'(LCD_E), 0);
        check("abort_cuenta", 32'(Cuenta), 0);
        check("abort_init", 32'(InitDone), 0);
        Lista = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        push_init();
        wait_init(1000);
        settle_and_check("reinit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
